// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_if;
    logic        freeze;
    logic        wb_en_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [4:0]  dest_in;
    logic [31:0] ALU_result;
    logic [31:0] st_val;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [4:0]  dest_out;
    logic [31:0] ALU_result_out;
    logic [31:0] mem_data_out;
    logic        addr_err;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;
    modport master (
        output freeze, wb_en_in, mem_r_en, mem_w_en, dest_in, ALU_result, st_val,
        input  wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_data_out, addr_err, ld_cnt, st_cnt
    );
    modport slave (
        input  freeze, wb_en_in, mem_r_en, mem_w_en, dest_in, ALU_result, st_val,
        output wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_data_out, addr_err, ld_cnt, st_cnt
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: word load/store against local data memory, MEM/WB register,
// sticky address-error flag and saturating load/store counters
module mem_stage #(
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [31:0] mem [DEPTH];
    logic [31:0] offset;
    logic        valid, ld, st, ill, err;
    // Below-base addresses wrap to a huge offset and fail the range test
    always_comb begin
        offset = bus.ALU_result - 32'(BASE_ADDR);
        valid  = offset[1:0] == 2'b00 && {2'b00, offset[31:2]} < 32'(DEPTH);
        st     = bus.mem_w_en && !bus.freeze;
        ld     = bus.mem_r_en && !bus.mem_w_en && !bus.freeze;
        ill    = bus.mem_r_en && bus.mem_w_en && !bus.freeze;
        err    = ((ld || st) && !valid) || ill;
    end
    always_ff @(posedge clk)
        if (st && valid) mem[offset[AW+1:2]] <= bus.st_val;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wb_en_out      <= 1'b0;
            bus.mem_r_en_out   <= 1'b0;
            bus.dest_out       <= '0;
            bus.ALU_result_out <= '0;
            bus.mem_data_out   <= '0;
            bus.addr_err       <= 1'b0;
            bus.ld_cnt         <= '0;
            bus.st_cnt         <= '0;
        end else if (!bus.freeze) begin
            bus.wb_en_out      <= bus.wb_en_in;
            bus.mem_r_en_out   <= bus.mem_r_en && !bus.mem_w_en;
            bus.dest_out       <= bus.dest_in;
            bus.ALU_result_out <= bus.ALU_result;
            bus.mem_data_out   <= (ld && valid) ? mem[offset[AW+1:2]] : '0;
            bus.addr_err       <= bus.addr_err || err;
            bus.ld_cnt         <= bus.ld_cnt + 16'(ld && bus.ld_cnt != 16'hFFFF);
            bus.st_cnt         <= bus.st_cnt + 16'(st && bus.st_cnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random stimulus against a behavioural model of the memory stage
module tb_mem_stage;
    localparam int DEPTH = 64;
    localparam int BASE  = 1024;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    mem_stage_if bus ();
    mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] mm [int];
    logic        e_wb, e_rd, e_err, e_known;
    logic [4:0]  e_dest;
    logic [31:0] e_alu, e_data;
    int          e_ld, e_st;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_all();
        chk("wb_en_out", 32'(bus.wb_en_out), 32'(e_wb));
        chk("mem_r_en_out", 32'(bus.mem_r_en_out), 32'(e_rd));
        chk("dest_out", 32'(bus.dest_out), 32'(e_dest));
        chk("ALU_result_out", bus.ALU_result_out, e_alu);
        if (e_known) chk("mem_data_out", bus.mem_data_out, e_data);
        chk("addr_err", 32'(bus.addr_err), 32'(e_err));
        chk("ld_cnt", 32'(bus.ld_cnt), 32'(e_ld));
        chk("st_cnt", 32'(bus.st_cnt), 32'(e_st));
    endtask
    task automatic model_reset();
        e_wb = 0; e_rd = 0; e_err = 0; e_known = 1;
        e_dest = 0; e_alu = 0; e_data = 0; e_ld = 0; e_st = 0;
    endtask
    task automatic model_step(input logic f, r, w, wb, input logic [4:0] d, input logic [31:0] a, s);
        logic [31:0] off;
        logic ok, load;
        if (f) return;
        off  = a - 32'(BASE);
        ok   = (off % 4 == 0) && (off / 4 < DEPTH);
        load = r && !w;
        e_known = 1;
        e_data  = 0;
        if (load && ok) begin
            e_known = mm.exists(int'(off / 4));
            if (e_known) e_data = mm[int'(off / 4)];
        end
        if (w && ok) mm[int'(off / 4)] = s;
        if (((r || w) && !ok) || (r && w)) e_err = 1;
        if (load && e_ld < 65535) e_ld++;
        if (w && e_st < 65535) e_st++;
        e_wb = wb; e_rd = load; e_dest = d; e_alu = a;
    endtask
    task automatic op(input logic f, r, w, wb, input logic [4:0] d, input logic [31:0] a, s, input bit quiet = 0);
        bus.freeze = f; bus.mem_r_en = r; bus.mem_w_en = w; bus.wb_en_in = wb;
        bus.dest_in = d; bus.ALU_result = a; bus.st_val = s;
        @(posedge clk);
        model_step(f, r, w, wb, d, a, s);
        #1;
        if (!quiet) check_all();
    endtask
    task automatic async_reset();
        #2 rst = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst = 1;
    endtask
    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
            3:       return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            4:       return 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 3));
            default: return 32'(BASE - 4 * $urandom_range(1, 3));
        endcase
    endfunction
    initial begin
        bus.freeze = 0; bus.mem_r_en = 0; bus.mem_w_en = 0; bus.wb_en_in = 0;
        bus.dest_in = 0; bus.ALU_result = 0; bus.st_val = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 1;
        op(0, 0, 1, 0, 5'd1, 32'd1032, 32'hDEADBEEF);
        op(0, 1, 0, 1, 5'd2, 32'd1032, 32'h0);
        chk("roundtrip_data", bus.mem_data_out, 32'hDEADBEEF);
        op(0, 0, 1, 0, 5'd3, 32'd1280, 32'h11111111);
        op(0, 1, 0, 1, 5'd3, 32'd1280, 32'h0);
        chk("oor_err", 32'(bus.addr_err), 32'd1);
        op(0, 1, 0, 1, 5'd4, 32'd1026, 32'h0);
        op(0, 0, 1, 0, 5'd5, 32'd1020, 32'h22222222);
        async_reset();
        op(0, 0, 1, 0, 5'd0, 32'd1024, 32'h0);
        op(1, 0, 1, 0, 5'd9, 32'd1024, 32'h5);
        op(1, 0, 1, 0, 5'd10, 32'd1024, 32'h5);
        op(1, 0, 1, 0, 5'd11, 32'd1024, 32'h5);
        op(0, 0, 1, 0, 5'd12, 32'd1024, 32'h5);
        chk("freeze_st_once", 32'(bus.st_cnt), 32'd2);
        op(0, 1, 0, 1, 5'd13, 32'd1024, 32'h0);
        op(0, 0, 0, 1, 5'd7, 32'h12345678, 32'h0);
        op(0, 0, 1, 0, 5'd1, 32'd1028, 32'hCAFEF00D);
        op(0, 1, 0, 1, 5'd2, 32'd1028, 32'h0);
        async_reset();
        op(0, 1, 0, 1, 5'd2, 32'd1028, 32'h0);
        chk("survive_reset", bus.mem_data_out, 32'hCAFEF00D);
        op(0, 1, 1, 1, 5'd6, 32'd1036, 32'hA5A5A5A5);
        op(0, 1, 0, 1, 5'd6, 32'd1036, 32'h0);
        for (int i = 0; i < 2000; i++)
            op(1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
               5'($urandom), rand_addr(), $urandom);
        async_reset();
        for (int i = 0; i < 65536; i++) op(0, 1, 0, 1, 5'd1, 32'd1024, 32'h0, 1);
        check_all();
        op(0, 1, 0, 1, 5'd1, 32'd1024, 32'h0);
        chk("ld_sat", 32'(bus.ld_cnt), 32'h0000FFFF);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, directly downstream of the execute stage. It takes the execute-stage ALU result as a byte address and performs word loads and stores against a local data memory. The outputs are registered as the MEM/WB pipeline register for write-back. It also keeps a sticky address-error flag and saturating load/store counters for bring-up debug.

## Interface
- DEPTH, 64: data memory size in 32-bit words; power of two, at most 1024.
- BASE_ADDR, 1024: byte address of word 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  pipeline hold; when 1, the stage performs no memory write and holds its outputs.
- wb_en_in  in  1  write-back enable from the EXE/MEM register.
- mem_r_en  in  1  load instruction.
- mem_w_en  in  1  store instruction.
- dest_in  in  5  destination register index.
- ALU_result  in  32  byte address for a load or store; pass-through value otherwise.
- st_val  in  32  store data.
- wb_en_out  out  1  registered write-back enable.
- mem_r_en_out  out  1  registered load flag; selects mem_data_out at write-back.
- dest_out  out  5  registered destination.
- ALU_result_out  out  32  registered ALU_result.
- mem_data_out  out  32  registered load data.
- addr_err  out  1  sticky address-error flag.
- ld_cnt  out  16  count of accepted loads, saturating.
- st_cnt  out  16  count of accepted stores, saturating.

## Operation
- **Address decode:**
  - offset = ALU_result − BASE_ADDR, 32-bit unsigned wrap.
  - idx = offset[31:2].
  - An access is valid when offset[1:0] == 0 and idx < DEPTH.
  - Addresses below BASE_ADDR wrap to a large offset and are therefore invalid.
- **Accepted access:** mem_r_en or mem_w_en is 1 and freeze == 0.
- **Store:**
  - Accepted and valid: mem[idx] ← st_val at the clock edge.
  - Accepted and invalid: no write.
- **Load:**
  - Accepted and valid: mem_data_out ← mem[idx].
  - Accepted and invalid: mem_data_out ← 0.
- **Non-load cycle (freeze == 0):** mem_data_out ← 0.
- **Both mem_r_en and mem_w_en = 1:** illegal encoding. The store is performed, the load is treated as not requested, and addr_err is set.
- **addr_err:** set on any accepted access with an invalid address, or on the illegal encoding. It stays set until reset.
- **Counters:**
  - ld_cnt increments on each accepted load (valid or not).
  - st_cnt increments on each accepted store (valid or not).
  - Both stop at 16'hFFFF.
- **Pass-through registers:** wb_en_out, mem_r_en_out, dest_out and ALU_result_out load their inputs every cycle with freeze == 0.
  - The registered mem_r_en_out is forced to 0 on the illegal encoding.
- **Freeze:** all registers and the memory keep their values.
- **Memory contents:** not reset and not initialised. Reading a word that has never been written returns X in simulation.

## Timing
- **Latency:** one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- **Store then load:** a store at edge N followed by a load of the same word at edge N+1 returns the new data. Only one instruction is present per cycle, so a read and a write never hit the same edge.
- **Reset (rst = 0):** takes effect immediately, independent of clk.
  - wb_en_out, mem_r_en_out, addr_err = 0.
  - dest_out = 0; ALU_result_out = 0; mem_data_out = 0.
  - ld_cnt = 0; st_cnt = 0.
- **Reset mid-operation:** a store sampled at the same edge as reset assertion is not guaranteed to be written. Memory contents survive reset.
- **Reset release:** first update on the first rising edge with rst = 1.
- **Freeze asserted with a store:** the store is held off until the edge where freeze == 0.

## Test plan
- **Store/load round trip.** Reset; store st_val=32'hDEADBEEF at ALU_result=1024+8, then load 1032.
  - mem_data_out=32'hDEADBEEF and mem_r_en_out=1 one cycle after the load.
  - st_cnt=1, ld_cnt=1, addr_err=0.
- **Out-of-range and misaligned addresses.**
  - Store to 1024+4·DEPTH (=1280), then load 1280 → mem_data_out=0, addr_err=1.
  - Load 1026 → mem_data_out=0; addr_err stays 1 until rst=0.
  - Address 1020 (below base) → invalid, no write.
- **Freeze.** Store 32'h5 to 1024 with freeze=1 for 3 cycles, changing dest_in meanwhile.
  - Outputs unchanged and st_cnt unchanged during freeze.
  - After freeze drops, the word is written once; a later load of 1024 returns 5.
- **Pass-through.** wb_en_in=1, dest_in=7, ALU_result=32'h12345678, no memory operation.
  - Next cycle: wb_en_out=1, dest_out=7, ALU_result_out=32'h12345678, mem_data_out=0.
- **Asynchronous reset mid-stream.** Assert rst=0 between clock edges after a load.
  - All outputs and counters go to 0 immediately.
  - A prior store to 1028 is still readable after release.
- **Illegal encoding and saturation.**
  - mem_r_en=mem_w_en=1 → store performed, mem_r_en_out=0, addr_err=1.
  - 65536 accepted loads → ld_cnt holds 16'hFFFF.
